// File: rtl/mmio_pwm.sv
// mmio_pwm: three-channel PWM responder on the data-memory bus, with prescaler,
// shared period counter, per-channel duty shadows and a sticky WRAP flag.
module mmio_pwm #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_F000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        write_mem,
    input  logic [2:0]  funct3,
    input  logic [31:0] write_address,
    input  logic [31:0] write_data,
    input  logic [31:0] read_address,
    output logic [31:0] read_data,
    output logic [2:0]  pwm
);

    localparam logic [2:0] PWM_IDLE = ACTIVE_LOW ? 3'b111 : 3'b000;

    logic [2:0]       enable;
    logic             run;
    logic [15:0]      prescale;
    logic [15:0]      period;
    logic [2:0][15:0] duty;
    logic [2:0][15:0] shadow;
    logic [15:0]      pre_cnt;
    logic [15:0]      count;
    logic             wrap;

    logic [7:0][31:0] reg_view;
    logic             write_hit;
    logic [2:0]       write_reg;
    logic [3:0]       lane_mask;
    logic [31:0]      lane_data;
    logic [31:0]      bit_mask;
    logic [31:0]      merged;
    logic             wrap_clear;
    logic             tick;
    logic             wrap_set;
    logic             read_hit;
    logic [31:0]      read_word;
    logic [7:0]       read_byte;
    logic [15:0]      read_half;
    logic [31:0]      load_value;
    logic [2:0]       channel_on;
    logic             unused_high;

    always_comb begin
        reg_view    = '0;
        reg_view[0] = {23'd0, run, 5'd0, enable};
        reg_view[1] = {16'd0, prescale};
        reg_view[2] = {16'd0, period};
        reg_view[3] = {16'd0, duty[0]};
        reg_view[4] = {16'd0, duty[1]};
        reg_view[5] = {16'd0, duty[2]};
        reg_view[6] = {16'd0, count};
        reg_view[7] = {31'd0, wrap};
    end

    // Stores merge the written byte lanes into the current register image.
    always_comb begin
        write_hit = write_mem && (write_address[31:5] == BASE_ADDR[31:5]);
        write_reg = write_address[4:2];
        lane_data = write_data;
        lane_mask = 4'b0000;
        case (funct3)
            3'b000: begin
                lane_mask = 4'b0001 << write_address[1:0];
                lane_data = {4{write_data[7:0]}};
            end
            3'b001: begin
                lane_mask = write_address[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{write_data[15:0]}};
            end
            3'b010:  lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
        if (!write_hit)
            lane_mask = 4'b0000;
        bit_mask   = {{8{lane_mask[3]}}, {8{lane_mask[2]}}, {8{lane_mask[1]}}, {8{lane_mask[0]}}};
        merged     = (reg_view[write_reg] & ~bit_mask) | (lane_data & bit_mask);
        wrap_clear = (write_reg == 3'd7) && bit_mask[0] && lane_data[0];
    end

    assign unused_high = ^merged[31:16];

    always_comb begin
        tick     = run && (pre_cnt == prescale);
        wrap_set = tick && (count >= period);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable   <= 3'b000;
            run      <= 1'b0;
            prescale <= 16'd0;
            period   <= 16'd0;
            duty     <= '0;
            wrap     <= 1'b0;
        end else begin
            if (lane_mask != 4'b0000) begin
                case (write_reg)
                    3'd0: begin
                        enable <= merged[2:0];
                        run    <= merged[8];
                    end
                    3'd1:    prescale <= merged[15:0];
                    3'd2:    period   <= merged[15:0];
                    3'd3:    duty[0]  <= merged[15:0];
                    3'd4:    duty[1]  <= merged[15:0];
                    3'd5:    duty[2]  <= merged[15:0];
                    default: ;
                endcase
            end
            // A hardware wrap in the same cycle as a clear keeps the flag set.
            if (wrap_set)
                wrap <= 1'b1;
            else if (wrap_clear)
                wrap <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= 16'd0;
            count   <= 16'd0;
            shadow  <= '0;
        end else if (!run) begin
            pre_cnt <= 16'd0;
            count   <= 16'd0;
            shadow  <= duty;
        end else if (tick) begin
            pre_cnt <= 16'd0;
            if (wrap_set) begin
                count  <= 16'd0;
                shadow <= duty;
            end else begin
                count <= count + 16'd1;
            end
        end else begin
            pre_cnt <= pre_cnt + 16'd1;
        end
    end

    always_comb begin
        read_hit  = read_address[31:5] == BASE_ADDR[31:5];
        read_word = reg_view[read_address[4:2]];
        case (read_address[1:0])
            2'd0:    read_byte = read_word[7:0];
            2'd1:    read_byte = read_word[15:8];
            2'd2:    read_byte = read_word[23:16];
            default: read_byte = read_word[31:24];
        endcase
        read_half = read_address[1] ? read_word[31:16] : read_word[15:0];
        case (funct3)
            3'b000:  load_value = {{24{read_byte[7]}}, read_byte};
            3'b100:  load_value = {24'd0, read_byte};
            3'b001:  load_value = {{16{read_half[15]}}, read_half};
            3'b101:  load_value = {16'd0, read_half};
            default: load_value = read_word;
        endcase
        if (!read_hit)
            load_value = 32'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            read_data <= 32'd0;
        else
            read_data <= load_value;
    end

    always_comb begin
        channel_on[0] = run && enable[0] && (count < shadow[0]);
        channel_on[1] = run && enable[1] && (count < shadow[1]);
        channel_on[2] = run && enable[2] && (count < shadow[2]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pwm <= PWM_IDLE;
        else
            pwm <= ACTIVE_LOW ? ~channel_on : channel_on;
    end

endmodule

// File: doc/mmio_pwm.md
# mmio_pwm

- Memory-mapped PWM peripheral; a responder on the core's data-memory bus. Decodes the same write/read port set the memory block sees: write strobe, funct3, write address/data, read address/data.
- Drives three PWM channels (the RGB LED pins) from a programmable prescaler, period and per-channel duty.
- Sits beside the memory block. The parent muxes `read_data` back to the core when the read address falls in this block's window.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_F000: 32-byte register window, aligned to 32 bytes.
- ACTIVE_LOW, 1: when 1, outputs drive 0 for "on" and 1 for "off".

Ports:
- clk  in  1  system clock. One clock only; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- write_mem  in  1  store strobe, sampled on the rising edge of clk.
- funct3  in  3  access size/sign, RISC-V encoding.
- write_address  in  32  store byte address.
- write_data  in  32  store data, in the low bits of the access.
- read_address  in  32  load byte address, presented every cycle.
- read_data  out  32  load result, registered.
- pwm  out  3  channel outputs: bit0 red, bit1 green, bit2 blue.

## Operation
- Select when address[31:5] == BASE_ADDR[31:5]. The register offset is address[4:2].
- Register map:
  - 0x00 CTRL: bits[2:0] channel enable; bit8 RUN.
  - 0x04 PRESCALE[15:0].
  - 0x08 PERIOD[15:0].
  - 0x0C/0x10/0x14 DUTY0/1/2[15:0].
  - 0x18 COUNT[15:0], read-only; writes ignored.
  - 0x1C STATUS: bit0 WRAP, sticky, write-1-to-clear.
  - Unimplemented bits read 0.
- Stores:
  - funct3 000 (SB) writes byte lane address[1:0].
  - funct3 001 (SH) writes halfword lane address[1].
  - funct3 010 (SW) writes the full word.
  - Any other funct3, or a store outside the window: no effect.
  - Bits beyond a register's width are discarded.
- Loads: read the selected word, then extract by registered funct3 and address[1:0]:
  - 000 LB: sign-extended byte.
  - 100 LBU: zero-extended byte.
  - 001 LH: sign-extended halfword.
  - 101 LHU: zero-extended halfword.
  - 010 LW and any other value: full word.
  - A load outside the window returns 32'h0.
- Counting when RUN=1:
  - pre_cnt increments each clock. When pre_cnt == PRESCALE, a tick occurs and pre_cnt returns to 0.
  - On a tick: if COUNT >= PERIOD, it is a wrap. COUNT goes to 0, WRAP is set, and the duty shadows load from DUTY0..2. Otherwise COUNT increments by 1.
  - Using `>=` means shrinking PERIOD below the current COUNT wraps at the next tick; the counter never runs through 16-bit overflow.
- Counting when RUN=0: pre_cnt and COUNT are held at 0, and the duty shadows track DUTY0..2 every cycle.
- Channel i is on when RUN & CTRL[i] & (COUNT < shadow_i):
  - DUTY=0 gives always off.
  - DUTY > PERIOD gives always on.
  - High time is DUTY ticks out of PERIOD+1 ticks.

## Timing
- Reset (asynchronous assert, all values held while rst=1):
  - Every register, pre_cnt, COUNT, shadows and read_data = 0.
  - pwm = 3'b111 when ACTIVE_LOW=1, 3'b000 otherwise.
- Store: takes effect at the edge where write_mem=1. It is visible to a load issued in the following cycle.
- Load latency: exactly 1 cycle. read_data at edge N+1 reflects read_address/funct3 sampled at edge N.
- Load and store to the same register in the same cycle: the load returns the old value.
- WRAP: a hardware set and a W1C in the same cycle leave WRAP=1 (set wins).
- Output timing:
  - pwm is registered, one cycle behind COUNT/CTRL changes.
  - A DUTY write while RUN=1 affects pwm only after the next wrap; there is no mid-period glitch.
- Tick rate: one tick every PRESCALE+1 clocks. PRESCALE=0 gives a tick every clock.
- Clearing RUN mid-period: COUNT is 0 and pwm is inactive by the second edge after the store.
- Reset mid-operation: outputs return to the inactive level immediately, without waiting for a clock.

## Test plan
- Reset then LW of each offset: all read 0 one cycle after the address; pwm = 3'b111 with ACTIVE_LOW=1.
- SW PERIOD=9, PRESCALE=0, DUTY0=3, CTRL=0x101: pwm[0] low 3 of every 10 clocks; COUNT reads cycle 0..9; STATUS.WRAP=1 after the first wrap; SW STATUS=1 clears it.
- SB 0xAB to BASE+0x0D, then LW DUTY0 returns 0x0000AB00. LB on the same byte returns 0xFFFFFFAB; LBU returns 0x000000AB.
- While running with DUTY1=2, SW DUTY1=8: high time stays 2 until COUNT wraps, then becomes 8. DUTY1=0 gives never on; DUTY1=10 with PERIOD=9 gives always on.
- PERIOD=100 with COUNT at 50, then SW PERIOD=20: the next tick wraps to 0 and sets WRAP. SW with funct3=3'b011, or SW to an address outside the window, leaves all registers unchanged.
- Assert rst for 1 clock mid-period with the counter running: COUNT=0 and pwm inactive immediately. No tick occurs until RUN is rewritten.
